// File: rtl/mem_arbiter.sv
// Two-requester round-robin front end for a single-ported data_memory.
// Each command runs IDLE -> BUSY -> RESP; misaligned/illegal commands skip the memory and report err.
module mem_arbiter #(
  parameter  int WIDTH  = 32,
  parameter  int SIZE   = 16,
  localparam int ADDR_W = $clog2(SIZE) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr_en0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [2:0]        funct3_0,
  input  logic [2:0]        funct3_1,
  input  logic [WIDTH-1:0]  wdata0,
  input  logic [WIDTH-1:0]  wdata1,
  output logic              ready0,
  output logic              ready1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic [WIDTH-1:0]  rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_data_in,
  output logic              mem_wr_en,
  output logic [2:0]        mem_funct3,
  input  logic [WIDTH-1:0]  mem_data_out
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        funct3;
    logic [WIDTH-1:0]  wdata;
  } cmd_t;

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;
  logic   grant1;
  logic   aligned;

  // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
  assign grant1 = req1 & (~req0 | ~last_grant_q);

  always_comb begin
    aligned = 1'b1;
    case (cmd_q.funct3[1:0])
      2'b01:   aligned = ~cmd_q.addr[0];
      2'b10:   aligned = (cmd_q.addr[1:0] == 2'b00);
      2'b11:   aligned = 1'b0;
      default: aligned = 1'b1;
    endcase
    if (~cmd_q.wr && (cmd_q.funct3[2:1] == 2'b11)) aligned = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ready0       = 1'b0;
    ready1       = 1'b0;
    done0        = 1'b0;
    done1        = 1'b0;
    err          = 1'b0;
    rdata        = '0;
    mem_wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          ready0       = ~grant1;
          ready1       = grant1;
          cmd_d        = grant1 ? cmd_t'{wr_en1, addr1, funct3_1, wdata1}
                                : cmd_t'{wr_en0, addr0, funct3_0, wdata0};
          owner_d      = grant1;
          last_grant_d = grant1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        mem_wr_en = cmd_q.wr & aligned;
        state_d   = RESP;
      end
      RESP: begin
        done0   = ~owner_q;
        done1   = owner_q;
        err     = ~aligned;
        rdata   = (aligned & ~cmd_q.wr) ? mem_data_out : '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset is synchronous, so outputs must be quiet combinationally in the reset cycle.
    if (reset) begin
      ready0    = 1'b0;
      ready1    = 1'b0;
      done0     = 1'b0;
      done1     = 1'b0;
      err       = 1'b0;
      rdata     = '0;
      mem_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign mem_addr    = cmd_q.addr;
  assign mem_data_in = cmd_q.wdata;
  assign mem_funct3  = cmd_q.funct3;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter with a byte-level reference model
// and a behavioural synchronous-read data_memory stand-in.
module tb_mem_arbiter;
  localparam int WIDTH = 32;
  localparam int SIZE  = 16;
  localparam int AW    = $clog2(SIZE) + 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0 = 0, req1 = 0, wr_en0 = 0, wr_en1 = 0;
  logic [AW-1:0]    addr0 = '0, addr1 = '0;
  logic [2:0]       funct3_0 = '0, funct3_1 = '0;
  logic [WIDTH-1:0] wdata0 = '0, wdata1 = '0;
  logic             ready0, ready1, done0, done1, err, mem_wr_en;
  logic [WIDTH-1:0] rdata, mem_data_in;
  logic [WIDTH-1:0] mem_data_out = '0;
  logic [AW-1:0]    mem_addr;
  logic [2:0]       mem_funct3;

  mem_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr_en0(wr_en0), .wr_en1(wr_en1),
    .addr0(addr0), .addr1(addr1), .funct3_0(funct3_0), .funct3_1(funct3_1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ready0(ready0), .ready1(ready1), .done0(done0), .done1(done1),
    .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr_en(mem_wr_en),
    .mem_funct3(mem_funct3), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // data_memory stand-in: word array, load extraction done by the memory.
  logic [31:0] stub_mem [SIZE] = '{default: '0};

  function automatic logic [31:0] stub_rd(input logic [31:0] w, input logic [1:0] bo,
                                          input logic [2:0] f3);
    logic [31:0] sh;
    sh = w >> (8 * int'(bo));
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_wr_en) begin
      case (mem_funct3[1:0])
        2'b00:   stub_mem[mem_addr[AW-1:2]][8*int'(mem_addr[1:0]) +: 8] <= mem_data_in[7:0];
        2'b01:   stub_mem[mem_addr[AW-1:2]][16*int'(mem_addr[1]) +: 16] <= mem_data_in[15:0];
        default: stub_mem[mem_addr[AW-1:2]] <= mem_data_in;
      endcase
    end
    mem_data_out <= stub_rd(stub_mem[mem_addr[AW-1:2]], mem_addr[1:0], mem_funct3);
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
  } cmd_t;

  cmd_t        q0[$], q1[$];
  cmd_t        cur;
  logic [7:0]  mbytes [SIZE*4] = '{default: '0};
  int          phase = 0;      // cycles into the current transaction (0 = free)
  bit          own = 0, last_g = 1, prev_rst = 0;
  int          checks = 0, failures = 0;
  int          grants[$];
  logic [31:0] got_rd[$];
  bit          got_err[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic cmd_t mk(input bit wr, input int a, input logic [2:0] f3, input logic [31:0] wd);
    cmd_t c;
    c.wr = wr; c.addr = AW'(a); c.f3 = f3; c.wd = wd;
    return c;
  endfunction

  function automatic bit legal(input cmd_t c);
    bit ok;
    case (c.f3[1:0])
      2'b01:   ok = !c.addr[0];
      2'b10:   ok = (c.addr[1:0] == 2'b00);
      2'b11:   ok = 0;
      default: ok = 1;
    endcase
    if (!c.wr && (c.f3 == 3'b110 || c.f3 == 3'b111)) ok = 0;
    return ok;
  endfunction

  function automatic logic [31:0] ref_load(input cmd_t c);
    int a;
    logic [15:0] h;
    a = int'(c.addr);
    h = {mbytes[(a+1) % (SIZE*4)], mbytes[a]};
    case (c.f3)
      3'b000:  return {{24{mbytes[a][7]}}, mbytes[a]};
      3'b100:  return {24'h0, mbytes[a]};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return {mbytes[a+3], mbytes[a+2], mbytes[a+1], mbytes[a]};
    endcase
  endfunction

  task automatic ref_store(input cmd_t c);
    int a;
    a = int'(c.addr);
    case (c.f3[1:0])
      2'b00: mbytes[a] = c.wd[7:0];
      2'b01: begin mbytes[a] = c.wd[7:0]; mbytes[a+1] = c.wd[15:8]; end
      default: for (int k = 0; k < 4; k++) mbytes[a+k] = c.wd[8*k +: 8];
    endcase
  endtask

  // One clock: drive inputs after the edge, check at the falling edge, advance the model.
  task automatic cycle(input bit rst);
    bit e_r0, e_r1, e_d0, e_d1, e_err, e_wr, win, ok;
    logic [31:0] e_rd;
    @(posedge clk); #1;
    reset = rst;
    req0 = (q0.size() > 0);
    if (req0) begin wr_en0 = q0[0].wr; addr0 = q0[0].addr; funct3_0 = q0[0].f3; wdata0 = q0[0].wd; end
    req1 = (q1.size() > 0);
    if (req1) begin wr_en1 = q1[0].wr; addr1 = q1[0].addr; funct3_1 = q1[0].f3; wdata1 = q1[0].wd; end
    @(negedge clk);
    {e_r0, e_r1, e_d0, e_d1, e_err, e_wr} = '0;
    e_rd = '0;
    if (rst) begin
      phase = 0; last_g = 1;
    end else begin
      case (phase)
        0: if (req0 || req1) begin
             win = (req0 && req1) ? !last_g : req1;
             if (win) begin e_r1 = 1; cur = q1.pop_front(); end
             else     begin e_r0 = 1; cur = q0.pop_front(); end
             own = win; last_g = win; phase = 1;
           end
        1: begin
             e_wr = cur.wr && legal(cur);
             chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
             chk("mem_funct3", 32'(mem_funct3), 32'(cur.f3));
             chk("mem_data_in", mem_data_in, cur.wd);
             phase = 2;
           end
        default: begin
             ok = legal(cur);
             e_d0 = !own; e_d1 = own; e_err = !ok;
             e_rd = (ok && !cur.wr) ? ref_load(cur) : 32'h0;
             if (ok && cur.wr) ref_store(cur);
             phase = 0;
           end
      endcase
    end
    chk("ready0", 32'(ready0), 32'(e_r0));
    chk("ready1", 32'(ready1), 32'(e_r1));
    chk("done0", 32'(done0), 32'(e_d0));
    chk("done1", 32'(done1), 32'(e_d1));
    chk("err", 32'(err), 32'(e_err));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
    if (rst || e_d0 || e_d1) chk("rdata", rdata, e_rd);
    if (prev_rst) begin
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_data_in", mem_data_in, 32'h0);
      chk("rst_mem_funct3", 32'(mem_funct3), 32'h0);
    end
    if (ready0) grants.push_back(0);
    if (ready1) grants.push_back(1);
    if (done0 || done1) begin got_rd.push_back(rdata); got_err.push_back(err); end
    prev_rst = rst;
  endtask

  task automatic run(input int max);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || phase != 0) && n < max) begin
      cycle(0);
      n++;
    end
    if (n >= max) begin
      checks++; failures++;
      $display("FAIL timeout pending0=%0d pending1=%0d phase=%0d", q0.size(), q1.size(), phase);
    end
  endtask

  function automatic logic [31:0] rd_at(input int i);
    return (got_rd.size() > i) ? got_rd[i] : 32'hxxxxxxxx;
  endfunction

  initial begin
    cycle(1);
    cycle(1);

    // lone request from requester 1 is granted in the very first IDLE cycle
    grants.delete();
    q1.push_back(mk(0, 'h00, 3'b010, 0));
    cycle(0);
    chk("solo_req1_grant", (grants.size() > 0) ? grants[0] : 9, 1);
    run(20);

    // store then load-back
    got_rd.delete();
    q0.push_back(mk(1, 'h0C, 3'b010, 32'hDEADBEEF));
    q0.push_back(mk(0, 'h0C, 3'b010, 0));
    run(30);
    chk("sw_lw_rdata", rd_at(1), 32'hDEADBEEF);

    // sub-word loads with sign/zero extension
    got_rd.delete();
    q0.push_back(mk(1, 'h10, 3'b010, 32'h3210F0F0));
    q0.push_back(mk(0, 'h10, 3'b001, 0));
    q0.push_back(mk(0, 'h10, 3'b101, 0));
    q0.push_back(mk(0, 'h10, 3'b000, 0));
    q0.push_back(mk(0, 'h10, 3'b100, 0));
    run(50);
    chk("lh", rd_at(1), 32'hFFFFF0F0);
    chk("lhu", rd_at(2), 32'h0000F0F0);
    chk("lb", rd_at(3), 32'hFFFFFFF0);
    chk("lbu", rd_at(4), 32'h000000F0);

    // misaligned halfword store is rejected and leaves memory alone
    q1.push_back(mk(1, 'h38, 3'b010, 32'hA5A55A5A));
    run(20);
    got_rd.delete(); got_err.delete();
    q1.push_back(mk(1, 'h39, 3'b001, 32'h00001234));
    q1.push_back(mk(0, 'h38, 3'b010, 0));
    run(30);
    chk("sh_mis_err", (got_err.size() > 0) ? 32'(got_err[0]) : 9, 1);
    chk("lw_after_err", (got_err.size() > 1) ? 32'(got_err[1]) : 9, 0);
    chk("lw_unchanged", rd_at(1), 32'hA5A55A5A);

    // both requesters held from reset: strict alternation starting with 0
    cycle(1);
    grants.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(0, 'h0C, 3'b010, 0));
      q1.push_back(mk(0, 'h10, 3'b010, 0));
    end
    run(60);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rr_grant%0d", i), (grants.size() > i) ? grants[i] : 9, i % 2);

    // reset during BUSY of a store drops it
    q0.push_back(mk(1, 'h04, 3'b010, 32'h11112222));
    run(20);
    q0.push_back(mk(1, 'h04, 3'b010, 32'h99998888));
    for (int n = 0; n < 10 && phase != 1; n++) cycle(0);
    chk("reached_busy", phase, 1);
    cycle(1);
    got_rd.delete();
    q0.push_back(mk(0, 'h04, 3'b010, 0));
    run(20);
    chk("rst_busy_prior", rd_at(0), 32'h11112222);

    // randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(0, 3) == 0) begin
          cmd_t c;
          c.wr = 1'($urandom_range(0, 1));
          c.addr = AW'($urandom_range(0, SIZE*4-1));
          c.f3 = c.wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
          c.wd = $urandom;
          if ($urandom_range(0, 1) == 1) c.addr[1:0] = 2'b00;
          if (r == 0) q0.push_back(c); else q1.push_back(c);
        end
      end
      cycle($urandom_range(0, 80) == 0);
    end
    run(5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
